// File: rtl/regfile_dump.sv
// regfile_dump: reads R0-R15 in pairs, snapshots Z/V/N at start, then streams 17 words over valid/ready
// Ports: clk/rst (sync, active-high); start begins a dump from IDLE; busy/done status;
//        SrcReg1/SrcReg2 -> SrcData1/SrcData2 register-file read ports; Z_out/V_out/N_out flags;
//        out_valid/out_ready/out_data/out_idx stream (idx 0-15 registers, 16 flag word).
module regfile_dump #(
   parameter int NUM_PAIRS = 8,
   parameter int DATA_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [3:0]        SrcReg1,
   output logic [3:0]        SrcReg2,
   input  logic [DATA_W-1:0] SrcData1,
   input  logic [DATA_W-1:0] SrcData2,
   input  logic              Z_out,
   input  logic              V_out,
   input  logic              N_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [4:0]        out_idx
);
   typedef enum logic [2:0] {IDLE, FETCH, SEND_LO, SEND_HI, SEND_FLAGS, DONE} state_t;
   state_t              r_state, w_next;
   logic [2:0]          r_k;
   logic [DATA_W-1:0]   r_lo, r_hi, r_flag;
   logic                w_hs, w_last;
   assign w_hs   = out_valid & out_ready;
   assign w_last = (r_k == 3'(NUM_PAIRS - 1));
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:       w_next = start ? FETCH : IDLE;
         FETCH:      w_next = SEND_LO;
         SEND_LO:    w_next = w_hs ? SEND_HI : SEND_LO;
         SEND_HI:    w_next = !w_hs ? SEND_HI : (w_last ? SEND_FLAGS : FETCH);
         SEND_FLAGS: w_next = w_hs ? DONE : SEND_FLAGS;
         default:    w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_k     <= '0;
         r_lo    <= '0;
         r_hi    <= '0;
         r_flag  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && start) begin
            r_k    <= '0;
            r_flag <= {{(DATA_W-3){1'b0}}, Z_out, V_out, N_out};
         end
         if (r_state == FETCH) begin
            r_lo <= SrcData1;
            r_hi <= SrcData2;
         end
         if (r_state == SEND_HI && w_hs && !w_last) r_k <= r_k + 3'd1;
         if (r_state == DONE) r_k <= '0;
      end
   end
   // every output is a pure decode of registered state; out_ready only steers w_next
   assign busy      = r_state inside {FETCH, SEND_LO, SEND_HI, SEND_FLAGS};
   assign done      = (r_state == DONE);
   assign out_valid = r_state inside {SEND_LO, SEND_HI, SEND_FLAGS};
   assign SrcReg1   = busy ? {r_k, 1'b0} : 4'd0;
   assign SrcReg2   = busy ? {r_k, 1'b1} : 4'd0;
   assign out_data  = (r_state == SEND_LO)    ? r_lo   :
                      (r_state == SEND_HI)    ? r_hi   :
                      (r_state == SEND_FLAGS) ? r_flag : '0;
   assign out_idx   = (r_state == SEND_LO)    ? {1'b0, r_k, 1'b0} :
                      (r_state == SEND_HI)    ? {1'b0, r_k, 1'b1} :
                      (r_state == SEND_FLAGS) ? 5'd16             : 5'd0;
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed + randomized checks of regfile_dump against a word-list reference model
module tb_regfile_dump;
   logic        clk = 0, rst = 1, start = 0, out_ready = 0;
   logic        Z_out = 0, V_out = 0, N_out = 0;
   logic        busy, done, out_valid;
   logic [3:0]  SrcReg1, SrcReg2;
   logic [15:0] SrcData1, SrcData2, out_data;
   logic [4:0]  out_idx;
   logic [15:0] regs [16];
   int          n_assert = 0, n_fail = 0;
   assign SrcData1 = regs[SrcReg1];
   assign SrcData2 = regs[SrcReg2];
   always #5 clk = ~clk;
   regfile_dump dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .SrcData1(SrcData1), .SrcData2(SrcData2),
      .Z_out(Z_out), .V_out(V_out), .N_out(N_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic check_idle();
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_valid", out_valid, 0);
      check("idle_src1", SrcReg1, 0);
      check("idle_src2", SrcReg2, 0);
   endtask
   // mode 0: ready always high, 1: ready pattern 1,0,0 repeating, 2: random ready
   task automatic dump(input int mode, input bit chg_flags, input bit start_in_done);
      logic [15:0] exp_q [$];
      logic [15:0] prev_data;
      logic [4:0]  prev_idx;
      bit          stall_prev, r;
      int          cyc, widx, fetch_n, busy_n;
      @(negedge clk);
      check_idle();
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(regs[i]);
      exp_q.push_back(16'(4 * Z_out + 2 * V_out + N_out));
      start = 1;
      cyc = 0; widx = 0; fetch_n = 0; busy_n = 0; stall_prev = 0;
      prev_data = 0; prev_idx = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (cyc == 1 && chg_flags) {Z_out, V_out, N_out} = ~{Z_out, V_out, N_out};
         if (cyc > 300) begin
            check("timeout", 0, 1);
            break;
         end
         if (done) begin
            if (mode == 0) check("done_cycle", cyc, 26);
            check("words_seen", widx, 17);
            check("fetches_seen", fetch_n, 8);
            check("busy_cycles", busy_n, cyc - 1);
            check("done_busy", busy, 0);
            check("done_valid", out_valid, 0);
            start = start_in_done;
            break;
         end
         if (cyc == 1) check("first_is_fetch", {busy, out_valid}, 2'b10);
         if (busy) busy_n++;
         if (stall_prev) begin
            check("stall_data", out_data, prev_data);
            check("stall_idx", out_idx, prev_idx);
         end
         if (busy && !out_valid) begin
            check("fetch_src1", SrcReg1, 2 * fetch_n);
            check("fetch_src2", SrcReg2, 2 * fetch_n + 1);
            fetch_n++;
         end
         r = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc - 1) % 3 == 0) : 1'($urandom_range(0, 1));
         out_ready = r;
         if (out_valid) begin
            check("word_idx", out_idx, widx);
            if (r) begin
               check("word_data", out_data, (widx < 17) ? exp_q[widx] : 16'hxxxx);
               widx++;
            end
         end
         stall_prev = out_valid && !r;
         prev_data = out_data;
         prev_idx = out_idx;
         start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   endtask
   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);
      regs[0] = 16'h0000;
      repeat (3) @(negedge clk);
      check_idle();
      check("rst_data", out_data, 0);
      check("rst_idx", out_idx, 0);
      rst = 0;
      {Z_out, V_out, N_out} = 3'b101;
      dump(0, 0, 0);
      dump(1, 0, 0);
      dump(0, 1, 0);
      // abort mid-dump while stalled on idx 5, with start also high: reset must win
      @(negedge clk);
      start = 1;
      out_ready = 1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         start = 0;
         out_ready = !(out_valid && out_idx == 5);
         if (out_valid && out_idx == 5) break;
      end
      check("reached_idx5", {out_valid, out_idx}, {1'b1, 5'd5});
      rst = 1;
      start = 1;
      @(negedge clk);
      rst = 0;
      start = 0;
      check_idle();
      check("abort_data", out_data, 0);
      check("abort_idx", out_idx, 0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("abort_no_done", {done, busy}, 2'b00);
      end
      dump(0, 0, 1);
      @(negedge clk);
      start = 0;
      check("done_start_ignored_a", busy, 0);
      @(negedge clk);
      check("done_start_ignored_b", busy, 0);
      dump(0, 0, 0);
      dump(0, 0, 0);
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
         {Z_out, V_out, N_out} = 3'($urandom);
         dump(2, t[0], 0);
      end
      @(negedge clk);
      check_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
